// File: rtl/video_timing_prog.sv
// video_timing_prog
// Programmable raster timing generator. Each line runs FP, SYNC, BP, ACTIVE
// and each frame does the same in lines. New timing is written into shadow
// registers with cfg_wr and copied to the working set at the frame wrap, so a
// frame is never built from a mix of old and new timing.
//
// Ports
//   clk, rst            pixel clock, asynchronous active-high reset
//   en                  0 freezes the counters and all raster outputs
//   cfg_*               new timing fields and sync polarities, taken on cfg_wr
//   cfg_wr              one-cycle strobe that captures every cfg_* input
//   win_x0/y0/w/h       sub-window inside the active area, sampled live
//   hs, vs, de          syncs (polarity programmable) and data enable
//   win_de              de restricted to the sub-window
//   x, y                active-area coordinates, held while de=0
//   sof, eol            start of frame, last active pixel of a line
//   cfg_pending         a shadow write is waiting for the frame wrap
//   cfg_err             one-cycle flag for a rejected write
module video_timing_prog #(
    parameter int CW      = 12,
    parameter int XW      = 11,
    parameter int D_HFP   = 88,
    parameter int D_HSYNC = 44,
    parameter int D_HBP   = 148,
    parameter int D_HACT  = 1920,
    parameter int D_VFP   = 4,
    parameter int D_VSYNC = 5,
    parameter int D_VBP   = 36,
    parameter int D_VACT  = 1080
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_h_act,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic [CW-1:0] cfg_v_act,
    input  logic          cfg_hs_pol,
    input  logic          cfg_vs_pol,
    input  logic          cfg_wr,
    input  logic [XW-1:0] win_x0,
    input  logic [XW-1:0] win_y0,
    input  logic [XW-1:0] win_w,
    input  logic [XW-1:0] win_h,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          win_de,
    output logic [XW-1:0] x,
    output logic [XW-1:0] y,
    output logic          sof,
    output logic          eol,
    output logic          cfg_pending,
    output logic          cfg_err
);

    localparam int TW = CW + 2;

    typedef struct packed {
        logic [CW-1:0] h_fp;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_bp;
        logic [CW-1:0] h_act;
        logic [CW-1:0] v_fp;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_bp;
        logic [CW-1:0] v_act;
        logic          hs_pol;
        logic          vs_pol;
    } timing_t;

    localparam timing_t DEF = {CW'(D_HFP), CW'(D_HSYNC), CW'(D_HBP), CW'(D_HACT),
                               CW'(D_VFP), CW'(D_VSYNC), CW'(D_VBP), CW'(D_VACT),
                               1'b1, 1'b1};

    timing_t       work;
    timing_t       shadow;
    timing_t       cfg_in;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;

    logic [TW-1:0] h_c, v_c;
    logic [TW-1:0] h_sync_end, h_blank, h_total;
    logic [TW-1:0] v_sync_end, v_blank, v_total;
    logic [TW-1:0] x_full, y_full;
    logic [XW-1:0] x_n, y_n;
    logic [XW:0]   x_ext, y_ext, x_hi, y_hi;
    logic          h_last, v_last, frame_wrap;
    logic          h_in_sync, v_in_sync, de_n, in_win, cfg_ok;

    assign cfg_in = {cfg_h_fp, cfg_h_sync, cfg_h_bp, cfg_h_act,
                     cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_v_act,
                     cfg_hs_pol, cfg_vs_pol};

    assign cfg_ok = (|cfg_h_sync) & (|cfg_h_act) & (|cfg_v_sync) & (|cfg_v_act);

    // All span boundaries are built two bits wider than the fields so that the
    // sum of four maximum-size fields cannot wrap.
    assign h_c        = TW'(h_cnt);
    assign v_c        = TW'(v_cnt);
    assign h_sync_end = TW'(work.h_fp) + TW'(work.h_sync);
    assign h_blank    = h_sync_end + TW'(work.h_bp);
    assign h_total    = h_blank + TW'(work.h_act);
    assign v_sync_end = TW'(work.v_fp) + TW'(work.v_sync);
    assign v_blank    = v_sync_end + TW'(work.v_bp);
    assign v_total    = v_blank + TW'(work.v_act);

    // >= rather than == keeps the counters bounded even if they were ever
    // beyond the end of the current totals.
    assign h_last     = h_c >= (h_total - TW'(1));
    assign v_last     = v_c >= (v_total - TW'(1));
    assign frame_wrap = en & h_last & v_last;

    assign h_in_sync  = (h_c >= TW'(work.h_fp)) && (h_c < h_sync_end);
    assign v_in_sync  = (v_c >= TW'(work.v_fp)) && (v_c < v_sync_end);
    assign de_n       = (h_c >= h_blank) && (v_c >= v_blank);

    assign x_full     = h_c - h_blank;
    assign y_full     = v_c - v_blank;
    assign x_n        = XW'(x_full);
    assign y_n        = XW'(y_full);

    assign x_ext      = {1'b0, x_n};
    assign y_ext      = {1'b0, y_n};
    assign x_hi       = {1'b0, win_x0} + {1'b0, win_w};
    assign y_hi       = {1'b0, win_y0} + {1'b0, win_h};
    assign in_win     = (win_w != '0) && (win_h != '0) &&
                        (x_ext >= {1'b0, win_x0}) && (x_ext < x_hi) &&
                        (y_ext >= {1'b0, win_y0}) && (y_ext < y_hi);

    // Configuration path runs regardless of en so writes are never lost. When a
    // write lands on the wrap edge the copy takes the old shadow and the later
    // assignment keeps the new write pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work        <= DEF;
            shadow      <= DEF;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= cfg_wr & ~cfg_ok;
            if (frame_wrap) begin
                work        <= shadow;
                cfg_pending <= 1'b0;
            end
            if (cfg_wr && cfg_ok) begin
                shadow      <= cfg_in;
                cfg_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            hs     <= 1'b0;
            vs     <= 1'b0;
            de     <= 1'b0;
            win_de <= 1'b0;
            x      <= '0;
            y      <= '0;
            sof    <= 1'b0;
            eol    <= 1'b0;
        end else if (en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + CW'(1);
            end else begin
                h_cnt <= h_cnt + CW'(1);
            end
            hs     <= h_in_sync ? work.hs_pol : ~work.hs_pol;
            vs     <= v_in_sync ? work.vs_pol : ~work.vs_pol;
            de     <= de_n;
            win_de <= de_n & in_win;
            if (de_n) begin
                x <= x_n;
                y <= y_n;
            end
            sof    <= (h_cnt == '0) && (v_cnt == '0);
            eol    <= de_n & h_last;
        end
    end

endmodule

// File: tb/tb_video_timing_prog.sv
// tb_video_timing_prog
// Directed bench for video_timing_prog. The reset defaults are shrunk to a
// 10 x 6 raster (h 1/2/2/5, v 1/1/1/3) so frame wraps come quickly; the main
// test timing is h 2/3/4/8, v 1/2/1/4 (17 x 8 raster). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_video_timing_prog;

    localparam int CW = 12;
    localparam int XW = 11;

    logic          clk = 1'b0;
    logic          rst, en, cfg_wr, cfg_hs_pol, cfg_vs_pol;
    logic [CW-1:0] cfg_h_fp, cfg_h_sync, cfg_h_bp, cfg_h_act;
    logic [CW-1:0] cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_v_act;
    logic [XW-1:0] win_x0, win_y0, win_w, win_h;
    logic          hs, vs, de, win_de, sof, eol, cfg_pending, cfg_err;
    logic [XW-1:0] x, y;

    video_timing_prog #(
        .CW(CW), .XW(XW),
        .D_HFP(1), .D_HSYNC(2), .D_HBP(2), .D_HACT(5),
        .D_VFP(1), .D_VSYNC(1), .D_VBP(1), .D_VACT(3)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp), .cfg_h_act(cfg_h_act),
        .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp), .cfg_v_act(cfg_v_act),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol), .cfg_wr(cfg_wr),
        .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
        .hs(hs), .vs(vs), .de(de), .win_de(win_de), .x(x), .y(y),
        .sof(sof), .eol(eol), .cfg_pending(cfg_pending), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int m_period, m_de, m_de_first, m_hs_hi, m_hs_first, m_vs_hi, m_vs_first;
    int m_win, m_eol, m_xsum, m_xmax;
    int steps;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_cfg(input int hfp, input int hsy, input int hbp, input int hac,
                          input int vfp, input int vsy, input int vbp, input int vac,
                          input logic hp, input logic vp);
        cfg_h_fp   = CW'(hfp);
        cfg_h_sync = CW'(hsy);
        cfg_h_bp   = CW'(hbp);
        cfg_h_act  = CW'(hac);
        cfg_v_fp   = CW'(vfp);
        cfg_v_sync = CW'(vsy);
        cfg_v_bp   = CW'(vbp);
        cfg_v_act  = CW'(vac);
        cfg_hs_pol = hp;
        cfg_vs_pol = vp;
        cfg_wr     = 1'b1;
        @(negedge clk);
        cfg_wr     = 1'b0;
    endtask

    task automatic wait_sof(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sof !== 1'b1 && n < 2000);
    endtask

    // Called on a sample where sof=1; gathers statistics up to the next sof.
    task automatic measure();
        int idx;
        idx = 0;
        m_de = 0; m_hs_hi = 0; m_vs_hi = 0; m_win = 0; m_eol = 0;
        m_xsum = 0; m_xmax = 0;
        m_de_first = -1; m_hs_first = -1; m_vs_first = -1;
        do begin
            if (de === 1'b1) begin
                m_de++;
                m_xsum += int'(x);
                if (int'(x) > m_xmax) m_xmax = int'(x);
                if (m_de_first < 0) m_de_first = idx;
            end
            if (hs === 1'b1) begin
                m_hs_hi++;
                if (m_hs_first < 0) m_hs_first = idx;
            end
            if (vs === 1'b1) begin
                m_vs_hi++;
                if (m_vs_first < 0) m_vs_first = idx;
            end
            if (win_de === 1'b1) m_win++;
            if (eol === 1'b1) m_eol++;
            @(negedge clk);
            idx++;
        end while (sof !== 1'b1 && idx < 2000);
        m_period = idx;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; cfg_wr = 1'b0;
        cfg_h_fp = '0; cfg_h_sync = '0; cfg_h_bp = '0; cfg_h_act = '0;
        cfg_v_fp = '0; cfg_v_sync = '0; cfg_v_bp = '0; cfg_v_act = '0;
        cfg_hs_pol = 1'b0; cfg_vs_pol = 1'b0;
        win_x0 = XW'(2); win_w = XW'(3); win_y0 = XW'(1); win_h = XW'(2);
        repeat (2) @(negedge clk);

        check_val("rst_hs", hs, 0);
        check_val("rst_vs", vs, 0);
        check_val("rst_de", de, 0);
        check_val("rst_win_de", win_de, 0);
        check_val("rst_x", x, 0);
        check_val("rst_y", y, 0);
        check_val("rst_sof", sof, 0);
        check_val("rst_eol", eol, 0);
        check_val("rst_pending", cfg_pending, 0);
        check_val("rst_err", cfg_err, 0);

        // Default 10 x 6 raster straight out of reset.
        rst = 1'b0;
        @(negedge clk);
        check_val("def_sof_first", sof, 1);
        measure();
        check_val("def_period", m_period, 60);
        check_val("def_de", m_de, 15);
        check_val("def_de_first", m_de_first, 35);
        check_val("def_hs_hi", m_hs_hi, 12);
        check_val("def_hs_first", m_hs_first, 1);
        check_val("def_vs_hi", m_vs_hi, 10);
        check_val("def_vs_first", m_vs_first, 10);
        check_val("def_xsum", m_xsum, 30);
        check_val("def_eol", m_eol, 3);
        check_val("def_win", m_win, 6);

        // Two writes mid-frame: the second one wins, old timing holds to the wrap.
        do_cfg(2, 3, 4, 16, 1, 2, 1, 4, 1'b1, 1'b1);
        do_cfg(2, 3, 4, 8, 1, 2, 1, 4, 1'b1, 1'b1);
        check_val("wr_pending", cfg_pending, 1);
        wait_sof(steps);
        check_val("wr_old_timing", steps, 58);
        check_val("wr_pending_clr", cfg_pending, 0);
        measure();
        check_val("new_period", m_period, 136);
        check_val("new_de", m_de, 32);
        check_val("new_de_first", m_de_first, 77);
        check_val("new_hs_hi", m_hs_hi, 24);
        check_val("new_hs_first", m_hs_first, 2);
        check_val("new_vs_hi", m_vs_hi, 34);
        check_val("new_vs_first", m_vs_first, 17);
        check_val("new_xsum", m_xsum, 112);
        check_val("new_xmax", m_xmax, 7);
        check_val("new_eol", m_eol, 4);
        check_val("new_win", m_win, 6);

        // Inverted polarities.
        do_cfg(2, 3, 4, 8, 1, 2, 1, 4, 1'b0, 1'b0);
        wait_sof(steps);
        check_val("pol0_wait", steps, 135);
        measure();
        check_val("pol0_period", m_period, 136);
        check_val("pol0_hs_hi", m_hs_hi, 112);
        check_val("pol0_vs_hi", m_vs_hi, 102);
        check_val("pol0_de", m_de, 32);

        // Rejected write: zero h_sync.
        do_cfg(2, 0, 4, 8, 1, 2, 1, 4, 1'b1, 1'b1);
        check_val("err_pulse", cfg_err, 1);
        check_val("err_pending", cfg_pending, 0);
        @(negedge clk);
        check_val("err_one_clk", cfg_err, 0);
        wait_sof(steps);
        check_val("err_wait", steps, 134);
        measure();
        check_val("err_period", m_period, 136);
        check_val("err_hs_hi", m_hs_hi, 112);

        // Write landing on the frame-wrap edge: old shadow applied, new one pending.
        repeat (134) @(negedge clk);
        do_cfg(2, 3, 4, 8, 1, 2, 1, 4, 1'b1, 1'b1);
        check_val("coin_pending", cfg_pending, 1);
        @(negedge clk);
        check_val("coin_sof", sof, 1);
        check_val("coin_still_pending", cfg_pending, 1);
        measure();
        check_val("coin_hs_hi_old", m_hs_hi, 112);
        check_val("coin_pending_clr", cfg_pending, 0);
        measure();
        check_val("coin_hs_hi_new", m_hs_hi, 24);
        check_val("coin_hs_first", m_hs_first, 2);

        // en=0 for 5 clocks on line 4, x=3.
        repeat (80) @(negedge clk);
        check_val("frz_x_before", x, 3);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("frz_x", x, 3);
            check_val("frz_de", de, 1);
        end
        check_val("frz_hs", hs, 0);
        check_val("frz_vs", vs, 0);
        en = 1'b1;
        wait_sof(steps);
        check_val("frz_wait", steps, 56);

        // Reset mid-frame with a write pending.
        repeat (20) @(negedge clk);
        do_cfg(2, 3, 4, 16, 1, 2, 1, 4, 1'b1, 1'b1);
        check_val("mrst_pending_before", cfg_pending, 1);
        rst = 1'b1;
        #1;
        check_val("mrst_pending", cfg_pending, 0);
        check_val("mrst_de", de, 0);
        check_val("mrst_x", x, 0);
        check_val("mrst_hs", hs, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("mrst_sof_first", sof, 1);
        measure();
        check_val("mrst_period", m_period, 60);
        check_val("mrst_de_cnt", m_de, 15);
        check_val("mrst_pending_after", cfg_pending, 0);
        measure();
        check_val("mrst_period2", m_period, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
